adder_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one single-issue adder datapath among N requesters. It owns the adder's `start`/`a`/`b` inputs and consumes its `y`/`valid` outputs. Each response is returned tagged with the requester index. Only one operation is in flight at a time. A watchdog flags an adder that never asserts `valid`; a second flag records a `valid` nobody asked for.

---
 rtl/adder_rr_scheduler_if.sv | 44 ++++
 rtl/adder_rr_scheduler.sv | 151 +++++++++++++++
 tb/tb_adder_rr_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_scheduler_if
// Brief    : Requester, response and adder-side signal bundle for the
//            round-robin adder scheduler.
// Revision : 1.0
// ============================================================================
interface adder_rr_scheduler_if #(
    parameter int W = 10,
    parameter int N = 4
);
    localparam int c_id_w = $clog2(N);

    logic [N-1:0]      req;
    logic [N*W-1:0]    a_in;
    logic [N*W-1:0]    b_in;
    logic [N-1:0]      gnt;
    logic              resp_valid;
    logic [c_id_w-1:0] resp_id;
    logic [W-1:0]      resp_y;
    logic              busy;
    logic              err_timeout;
    logic              err_spurious;
    logic              add_start;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_y;
    logic              add_valid;

    // Scheduler view
    modport master (
        input  req, a_in, b_in, add_y, add_valid,
        output gnt, resp_valid, resp_id, resp_y, busy,
               err_timeout, err_spurious, add_start, add_a, add_b
    );

    // Requesters plus adder view
    modport slave (
        output req, a_in, b_in, add_y, add_valid,
        input  gnt, resp_valid, resp_id, resp_y, busy,
               err_timeout, err_spurious, add_start, add_a, add_b
    );
endinterface
`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_scheduler
// Brief    : Round-robin scheduler sharing one single-issue adder among N
//            requesters, with a no-valid watchdog and a spurious-valid flag.
// Revision : 1.0
// ============================================================================
module adder_rr_scheduler #(
    parameter int W       = 10,
    parameter int N       = 4,
    parameter int TIMEOUT = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    adder_rr_scheduler_if.master bus
);
    localparam int c_id_w  = $clog2(N);
    localparam int c_cnt_w = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_id_w-1:0]  c_id_last  = c_id_w'(N - 1);

    logic [1:0]         r_state;
    logic [c_id_w-1:0]  r_ptr;
    logic [c_id_w-1:0]  r_id;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N-1:0]       r_gnt;
    logic               r_start;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_resp_valid;
    logic [c_id_w-1:0]  r_resp_id;
    logic [W-1:0]       r_resp_y;
    logic               r_busy;
    logic               r_err_to;
    logic               r_err_sp;

    logic [W-1:0]       w_a_arr [N];
    logic [W-1:0]       w_b_arr [N];
    logic               w_any;
    logic [c_id_w-1:0]  w_win;
    logic [c_id_w-1:0]  w_ptr_next;
    logic [N-1:0]       w_gnt;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_a_arr[i] = bus.a_in[i*W +: W];
        assign w_b_arr[i] = bus.b_in[i*W +: W];
    end

    // First requester at or after the pointer, scanning upward with wrap
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_any && bus.req[idx]) begin
                w_any = 1'b1;
                w_win = c_id_w'(idx);
            end
        end
    end

    always_comb begin
        w_gnt        = '0;
        w_gnt[w_win] = w_any;
        w_ptr_next   = (w_win == c_id_last) ? '0 : w_win + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_ptr        <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_gnt        <= '0;
            r_start      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_y     <= '0;
            r_busy       <= 1'b0;
            r_err_to     <= 1'b0;
            r_err_sp     <= 1'b0;
        end else begin
            r_gnt        <= '0;
            r_start      <= 1'b0;
            r_resp_valid <= 1'b0;

            if (bus.add_valid && (r_state != c_wait)) r_err_sp <= 1'b1;

            case (r_state)
                c_idle: begin
                    if (w_any) begin
                        r_gnt   <= w_gnt;
                        r_start <= 1'b1;
                        r_a     <= w_a_arr[w_win];
                        r_b     <= w_b_arr[w_win];
                        r_id    <= w_win;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b1;
                        r_state <= c_issue;
                    end
                end
                c_issue: begin
                    r_cnt   <= '0;
                    r_state <= c_wait;
                end
                c_wait: begin
                    if (bus.add_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_y     <= bus.add_y;
                        r_resp_id    <= r_id;
                        r_busy       <= 1'b0;
                        r_state      <= c_idle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        // Abandon the op: the adder is presumed hung
                        if (r_cnt == c_cnt_last) begin
                            r_err_to <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= c_idle;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.gnt          = r_gnt;
    assign bus.add_start    = r_start;
    assign bus.add_a        = r_a;
    assign bus.add_b        = r_b;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_id      = r_resp_id;
    assign bus.resp_y       = r_resp_y;
    assign bus.busy         = r_busy;
    assign bus.err_timeout  = r_err_to;
    assign bus.err_spurious = r_err_sp;
endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_rr_scheduler
// Brief    : Self-checking bench for adder_rr_scheduler with an adder model.
// Revision : 1.0
// ============================================================================
module tb_adder_rr_scheduler;
    localparam int W       = 10;
    localparam int N       = 4;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_rr_scheduler_if #(.W(W), .N(N)) bus();

    adder_rr_scheduler #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Conforming adder (start |=> valid), gated by adder_en; inject forces a stray valid
    logic         adder_en = 1'b1;
    logic         inject   = 1'b0;
    logic         m_valid  = 1'b0;
    logic [W-1:0] m_y      = '0;
    always @(posedge clk) begin
        m_valid <= adder_en & bus.add_start;
        m_y     <= bus.add_a + bus.add_b;
    end
    assign bus.add_valid = m_valid | inject;
    assign bus.add_y     = m_y;

    int           tests = 0;
    int           fails = 0;
    int           m_ptr = 0;
    bit           m_err_to = 1'b0;
    bit           m_err_sp = 1'b0;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++)
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            opa[i] = W'($urandom_range(0, 1023));
            opb[i] = W'($urandom_range(0, 1023));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        bus.req  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_err_to = 1'b0;
        m_err_sp = 1'b0;
    endtask

    // One transaction: drive mask in IDLE, follow it to the response or timeout
    task automatic serve(input logic [N-1:0] mask, input bit ok);
        int win;
        int busy_cyc;
        bit saw_resp;
        win = pick(mask, m_ptr);
        for (int i = 0; i < N; i++) begin
            bus.a_in[i*W +: W] = opa[i];
            bus.b_in[i*W +: W] = opb[i];
        end
        bus.req  = mask;
        adder_en = ok;
        @(negedge clk);
        check("gnt", bus.gnt, 32'(1) << win);
        check("add_start", bus.add_start, 1);
        check("add_a", bus.add_a, opa[win]);
        check("add_b", bus.add_b, opb[win]);
        check("busy_issue", bus.busy, 1);
        bus.req = '0;
        m_ptr   = (win + 1) % N;
        if (ok) begin
            @(negedge clk);
            check("gnt_clear", bus.gnt, 0);
            check("start_clear", bus.add_start, 0);
            check("resp_early", bus.resp_valid, 0);
            check("busy_wait", bus.busy, 1);
            @(negedge clk);
            check("resp_valid", bus.resp_valid, 1);
            check("resp_id", bus.resp_id, win);
            check("resp_y", bus.resp_y, (int'(opa[win]) + int'(opb[win])) % 1024);
            check("busy_done", bus.busy, 0);
        end else begin
            busy_cyc = 1;
            saw_resp = 1'b0;
            for (int c = 0; c < 20 && bus.busy; c++) begin
                @(negedge clk);
                if (bus.busy) busy_cyc++;
                if (bus.resp_valid) saw_resp = 1'b1;
            end
            m_err_to = 1'b1;
            check("busy_cycles", busy_cyc, TIMEOUT + 1);
            check("no_resp", saw_resp, 0);
        end
        check("err_timeout", bus.err_timeout, m_err_to);
        check("err_spurious", bus.err_spurious, m_err_sp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_add_start", bus.add_start, 0);
        check("rst_err", {bus.err_timeout, bus.err_spurious}, 0);
        check("rst_add_a", bus.add_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request
        rand_ops();
        opa[2] = 10'd100;
        opb[2] = 10'd200;
        serve(4'b0100, 1'b1);

        // Fairness from a fresh pointer, then pointer wrap
        do_reset();
        for (int t = 0; t < 8; t++) begin
            rand_ops();
            serve(4'b1111, 1'b1);
        end
        rand_ops();
        serve(4'b1010, 1'b1);
        rand_ops();
        serve(4'b1010, 1'b1);

        // Datapath wrap
        rand_ops();
        opa[0] = 10'd1023;
        opb[0] = 10'd1;
        serve(4'b0001, 1'b1);

        for (int t = 0; t < 10; t++) begin
            rand_ops();
            serve(4'($urandom_range(1, 15)), 1'b1);
        end

        // Timeout, then normal service with sticky error
        rand_ops();
        serve(4'($urandom_range(1, 15)), 1'b0);
        rand_ops();
        serve(4'($urandom_range(1, 15)), 1'b1);

        // Reset during WAIT
        rand_ops();
        for (int i = 0; i < N; i++) begin
            bus.a_in[i*W +: W] = opa[i];
            bus.b_in[i*W +: W] = opb[i];
        end
        adder_en = 1'b0;
        bus.req  = 4'b1000;
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_outs", {bus.gnt, bus.add_start, bus.resp_valid, bus.err_timeout, bus.err_spurious}, 0);
        check("arst_data", {bus.resp_id, bus.resp_y, bus.add_a, bus.add_b}, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_err_to = 1'b0;
        m_err_sp = 1'b0;
        adder_en = 1'b1;

        // Stray valid in IDLE
        inject = 1'b1;
        @(negedge clk);
        inject   = 1'b0;
        m_err_sp = 1'b1;
        check("spur_flag", bus.err_spurious, 1);
        check("spur_no_resp", bus.resp_valid, 0);
        @(negedge clk);
        check("spur_no_resp2", bus.resp_valid, 0);
        check("spur_idle", bus.busy, 0);
        rand_ops();
        serve(4'b1111, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
